hex_display_mux: RTL

Two-digit multiplexed seven-segment driver: the output-side counterpart of the keypad encoder. The keypad encoder turns scanned key lines into a hex nibble. This block turns an 8-bit value (typically the ALU result) back into two time-multiplexed hex glyphs on shared segment lines. New values are loaded through a load/busy handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/hex_display_mux.sv | 105 ++++++++++
 1 files changed

// File: rtl/hex_display_mux.sv
// Two-digit multiplexed hex seven-segment driver; optional leading-zero blanking via HEX_DISPLAY_LZB_EN.
// Latency: outputs are registered one cycle behind slot state; a committed value shows from the next frame_tick.
// Backpressure: none on load (latest write wins); busy flags a value waiting for the frame boundary.
module hex_display_mux #(
    parameter logic [23:0] REFRESH_DIV = 24'd10_000,
    parameter logic [23:0] GUARD       = 24'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic [1:0] dp_in,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_en,
    output logic       frame_tick
);

    logic [23:0] r_k;
    logic        r_idx;
    logic [9:0]  r_disp;
    logic [9:0]  r_pend;
    logic        r_pflag;

    logic        w_last_k;
    logic        w_boundary;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign w_last_k   = (r_k == REFRESH_DIV - 24'd1);
    assign w_boundary = w_last_k && r_idx;
    assign w_nib      = r_idx ? r_disp[7:4] : r_disp[3:0];

    always_comb begin
        w_seg_nxt = glyph(w_nib);
`ifdef HEX_DISPLAY_LZB_EN
        if (r_idx && (r_disp[7:4] == 4'h0)) begin
            w_seg_nxt = 7'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_idx      <= 1'b0;
            r_disp     <= '0;
            r_pend     <= '0;
            r_pflag    <= 1'b0;
            busy       <= 1'b0;
            seg        <= '0;
            dp         <= 1'b0;
            digit_en   <= '0;
            frame_tick <= 1'b0;
        end else begin
            r_k <= w_last_k ? '0 : r_k + 24'd1;
            if (w_last_k) begin
                r_idx <= ~r_idx;
            end

            // Only a value pending before the boundary edge is committed;
            // a load on that same edge stays pending for the next frame.
            if (w_boundary && r_pflag) begin
                r_disp <= r_pend;
            end
            if (load) begin
                r_pend  <= {dp_in, data_in};
                r_pflag <= 1'b1;
            end else if (w_boundary) begin
                r_pflag <= 1'b0;
            end

            seg        <= w_seg_nxt;
            dp         <= r_idx ? r_disp[9] : r_disp[8];
            digit_en   <= (r_k < GUARD) ? 2'b00 : (r_idx ? 2'b10 : 2'b01);
            frame_tick <= (r_k == '0) && !r_idx;
            busy       <= r_pflag;
        end
    end

endmodule
